// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: drains bytes from a FIFO read port, packs them into
// 8-bit or big-endian 16-bit words and keeps a running byte count and XOR
// checksum for the current drain session.
module fifo_drain_reader #(
   parameter int RD_GAP = 1,   // idle cycles after each read pulse (1..3)
   parameter int CNT_W  = 8    // width of byte_count
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             init,
   input  logic             BIG,
   input  logic             empty,
   input  logic [7:0]       DATA_OUT,
   output logic             read,
   output logic [15:0]      data_word,
   output logic             word_valid,
   output logic             partial,
   output logic [CNT_W-1:0] byte_count,
   output logic [7:0]       checksum,
   output logic             idle
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   localparam logic [1:0] GAP_LOAD = 2'(RD_GAP);

   state_t           state_q, state_d;
   logic             read_q, read_d;
   logic [1:0]       gap_q, gap_d;
   logic             cap_q, cap_d;        // DATA_OUT holds a byte this cycle
   logic             big_q, big_d;
   logic [7:0]       half_q, half_d;      // high byte waiting for its partner
   logic             half_vld_q, half_vld_d;
   logic [15:0]      data_q, data_d;
   logic             wv_q, wv_d;
   logic             part_q, part_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       csum_q, csum_d;
   logic             idle_q, idle_d;

   // Next-state, read scheduling, byte capture and word assembly.
   always_comb begin
      state_d    = state_q;
      read_d     = 1'b0;
      gap_d      = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
      cap_d      = read_q;
      big_d      = big_q;
      half_d     = half_q;
      half_vld_d = half_vld_q;
      data_d     = data_q;
      wv_d       = 1'b0;
      part_d     = 1'b0;
      cnt_d      = cnt_q;
      csum_d     = csum_q;

      // A read issued last cycle delivers its byte now, whatever the state.
      if (cap_q) begin
         cnt_d  = cnt_q + CNT_W'(1);
         csum_d = csum_q ^ DATA_OUT;
         if (!big_q) begin
            wv_d   = 1'b1;
            data_d = {8'h00, DATA_OUT};
         end else if (!half_vld_q) begin
            half_d     = DATA_OUT;
            half_vld_d = 1'b1;
         end else begin
            wv_d       = 1'b1;
            data_d     = {half_q, DATA_OUT};
            half_vld_d = 1'b0;
         end
      end

      case (state_q)
         ST_IDLE: begin
            // Nothing is outstanding here, so a fresh session can start cleanly.
            if (init) begin
               state_d    = ST_ACTIVE;
               big_d      = BIG;
               cnt_d      = '0;
               csum_d     = 8'h00;
               half_d     = 8'h00;
               half_vld_d = 1'b0;
            end
         end
         ST_ACTIVE: begin
            if (!init) begin
               state_d = ST_FLUSH;
            end else if (!empty && !read_q && (gap_q == 2'd0)) begin
               read_d = 1'b1;
               gap_d  = GAP_LOAD;
            end
         end
         ST_FLUSH: begin
            // Leave only once the last issued read has been captured.
            if (!read_q && !cap_q) begin
               if (half_vld_q) begin
                  wv_d       = 1'b1;
                  part_d     = 1'b1;
                  data_d     = {half_q, 8'h00};
                  half_vld_d = 1'b0;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      idle_d = (state_d == ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         read_q     <= 1'b0;
         gap_q      <= 2'd0;
         cap_q      <= 1'b0;
         big_q      <= 1'b0;
         half_q     <= 8'h00;
         half_vld_q <= 1'b0;
         data_q     <= 16'h0000;
         wv_q       <= 1'b0;
         part_q     <= 1'b0;
         cnt_q      <= '0;
         csum_q     <= 8'h00;
         idle_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         read_q     <= read_d;
         gap_q      <= gap_d;
         cap_q      <= cap_d;
         big_q      <= big_d;
         half_q     <= half_d;
         half_vld_q <= half_vld_d;
         data_q     <= data_d;
         wv_q       <= wv_d;
         part_q     <= part_d;
         cnt_q      <= cnt_d;
         csum_q     <= csum_d;
         idle_q     <= idle_d;
      end
   end

   assign read       = read_q;
   assign data_word  = data_q;
   assign word_valid = wv_q;
   assign partial    = part_q;
   assign byte_count = cnt_q;
   assign checksum   = csum_q;
   assign idle       = idle_q;

endmodule

// File: doc/fifo_drain_reader.md
Name: fifo_drain_reader

Overview:
- Consumer-side counterpart to the FIFO write stimulus: drains bytes from a FIFO read port and assembles them into 8-bit or 16-bit words.
- Sits between the FIFO output (DATA_OUT, empty) and downstream checking logic.
- Issues read pulses, captures DATA_OUT, packs bytes (big-endian when BIG=1), and keeps a running byte count and XOR checksum.

Parameters:
- RD_GAP, 1, idle cycles forced after each read pulse so the FIFO empty flag settles (legal range 1..3).
- CNT_W, 8, width of byte_count.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- init  input  1  enable; 1 = drain FIFO, falling edge = finish and flush.
- BIG  input  1  0 = byte mode, 1 = 16-bit big-endian word mode; latched on entry to ACTIVE.
- empty  input  1  FIFO empty flag; updates the cycle after a read.
- DATA_OUT  input  8  FIFO read data; valid the cycle after read=1.
- read  output  1  registered single-cycle FIFO read strobe.
- data_word  output  16  assembled word.
- word_valid  output  1  single-cycle qualifier for data_word.
- partial  output  1  high with word_valid when a BIG-mode word was padded on flush.
- byte_count  output  CNT_W  bytes captured since entering ACTIVE; wraps modulo 2^CNT_W.
- checksum  output  8  XOR of all bytes captured since entering ACTIVE.
- idle  output  1  1 when FSM is in IDLE.

Behaviour:
- Reset (RESET=1 at a rising edge): state=IDLE; read=0, data_word=0, word_valid=0, partial=0, byte_count=0, checksum=0, idle=1. Half-word register, latched BIG and gap counter are cleared. Reset overrides everything, including mid-word and mid-read; any in-flight FIFO byte is discarded.
- FSM states: IDLE, ACTIVE, FLUSH.
- IDLE -> ACTIVE when init=1.
  - On this transition: latch BIG, clear byte_count, checksum and half-word.
  - idle=0 from the next cycle.
- ACTIVE:
  - read is asserted for the next cycle iff empty=0, read is currently 0, and the gap counter is 0.
  - After each read, the gap counter loads RD_GAP and decrements to 0.
  - Max rate is one read per RD_GAP+1 cycles.
- Capture timing:
  - A byte is captured at the edge ending the cycle after read=1 (cycle t+1 when read was high in cycle t).
  - On capture: checksum ^= byte; byte_count += 1.
- Byte mode (latched BIG=0): word_valid=1 in cycle t+2 with data_word={8'h00, byte}, partial=0.
- Word mode (latched BIG=1):
  - First byte of a pair is stored as the high byte; no output.
  - Second byte produces word_valid=1 in cycle t+2 with data_word={first, second}.
- ACTIVE -> FLUSH when init=0.
  - No new read is issued from that cycle on.
  - A read already issued is still captured.
- FLUSH:
  - Waits until no capture is outstanding.
  - If a half-word is pending in word mode: one word_valid with data_word={high, 8'h00} and partial=1.
  - Then -> IDLE.
  - FLUSH lasts 1–3 cycles.
- idle=1 is registered and follows the IDLE state.
- byte_count and checksum hold their final values in IDLE until the next IDLE -> ACTIVE transition.
- If init re-asserts while in FLUSH, the flush completes and IDLE -> ACTIVE follows on the next cycle; no byte is lost or duplicated.
- empty is ignored outside ACTIVE.
- Changes to BIG while in ACTIVE or FLUSH have no effect.
- word_valid and read are never high for more than one consecutive cycle.

Test Plan:
- Reset: hold RESET=1 for 2 cycles with init=1 and empty=0 -> all outputs 0, idle=1, read never asserted.
- Byte mode: FIFO preloaded with AA, BB, CC, DD, EE; BIG=0; init=1 -> read pulses every 2 cycles (RD_GAP=1); word_valid outputs 00AA, 00BB, 00CC, 00DD, 00EE, each 2 cycles after its read; final byte_count=5, checksum=EE.
- Word mode with flush: same data, BIG=1; init dropped after the 5th read -> words AABB and CCDD with partial=0, then EE00 with partial=1; byte_count=5, checksum=EE; idle=1 within 3 cycles.
- Empty stall: FIFO holds AA only; refill with BB 6 cycles later -> no read while empty=1; read resumes within 2 cycles of empty=0; outputs 00AA then 00BB.
- Reset mid-word: BIG=1; RESET after the first byte AA is captured -> no word_valid; outputs cleared; a re-run after reset starts a fresh pair (BB, CC -> BBCC).
- Wrap: CNT_W=8; 257 bytes of 8'h01 in byte mode -> byte_count=1, checksum=01.
